// File: rtl/booth_datapath_pkg.sv
// Shared constants for the radix-2 Booth multiplier.
// Control-word bit indices are common to the control unit and datapath.
package booth_pkg;
    localparam int W      = 8;
    localparam int N_ITER = 8;
    localparam int CW     = 7;

    localparam int C_INIT = 0;
    localparam int C_LDM  = 1;
    localparam int C_ADD  = 2;
    localparam int C_SUB  = 3;
    localparam int C_SHR  = 4;
    localparam int C_OUTH = 5;
    localparam int C_OUTL = 6;

    typedef logic [CW-1:0] ctrl_t;
endpackage

// File: rtl/booth_datapath_if.sv
// Control-unit <-> datapath bundle: operands, control word, scan/status, product.
interface booth_datapath_if #(
    parameter int W = booth_pkg::W
);
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [6:0]     c;
    logic [1:0]     q;
    logic           counted7;
    logic [2*W-1:0] product;
    logic           product_valid;

    modport master (
        output x, y, c,
        input  q, counted7, product, product_valid
    );

    modport slave (
        input  x, y, c,
        output q, counted7, product, product_valid
    );
endinterface

// File: rtl/booth_datapath_addsub.sv
// Combinational (W+1)-bit adder/subtractor for the Booth accumulator.
module booth_addsub
    import booth_pkg::*;
(
    input  logic [W:0] a,
    input  logic [W:0] m,
    input  logic       sub,
    output logic [W:0] sum
);
    assign sum = sub ? (a - m) : (a + m);
endmodule

// File: rtl/booth_datapath.sv
// Booth multiplier datapath: M/A/Q/Q-1 registers, iteration counter
// and registered product, driven by the control word from the FSM.
module booth_datapath
    import booth_pkg::*;
(
    input  logic             clk,
    input  logic             rst_b,
    booth_datapath_if.slave  bus
);
    localparam logic [2:0] CNT_LAST = 3'(N_ITER - 1);

    logic [W:0]     m_r;
    logic [W:0]     a_r;
    logic [W-1:0]   q_r;
    logic           qm1;
    logic [2:0]     cnt;
    logic           done;
    logic [2*W-1:0] product;
    logic           product_valid;
    logic [W:0]     sum;
    logic [W:0]     a_nxt;

    booth_addsub u_addsub (
        .a   (a_r),
        .m   (m_r),
        .sub (bus.c[C_SUB]),
        .sum (sum)
    );

    // Add-then-shift if both are ever raised together.
    always_comb begin
        a_nxt = a_r;
        if (bus.c[C_ADD]) a_nxt = sum;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            m_r           <= '0;
            a_r           <= '0;
            q_r           <= '0;
            qm1           <= 1'b0;
            cnt           <= '0;
            done          <= 1'b0;
            product       <= '0;
            product_valid <= 1'b0;
        end else begin
            if (bus.c[C_LDM]) m_r <= {bus.x[W-1], bus.x};
            if (bus.c[C_INIT]) begin
                a_r  <= '0;
                q_r  <= bus.y;
                qm1  <= 1'b0;
                cnt  <= '0;
                done <= 1'b0;
            end else if (bus.c[C_SHR]) begin
                {a_r, q_r, qm1} <= {a_nxt[W], a_nxt, q_r};
                cnt <= cnt + 3'd1;
                if (cnt == CNT_LAST) done <= 1'b1;
            end else if (bus.c[C_ADD]) begin
                a_r <= sum;
            end
            if (bus.c[C_OUTH]) product[2*W-1:W] <= a_r[W-1:0];
            if (bus.c[C_OUTL]) product[W-1:0]   <= q_r;
            product_valid <= bus.c[C_OUTH] | bus.c[C_OUTL];
        end
    end

    assign bus.q             = {q_r[0], qm1};
    assign bus.counted7      = done;
    assign bus.product       = product;
    assign bus.product_valid = product_valid;
endmodule

// File: tb/tb_booth_datapath.sv
// Scoreboard bench for booth_datapath; the bench itself plays the control unit.
module tb_booth_datapath;
    import booth_pkg::*;

    localparam logic [6:0] C_IDLE_V = 7'b0000011;
    localparam logic [6:0] C_ADD_V  = 7'b0000100;
    localparam logic [6:0] C_SUB_V  = 7'b0001100;
    localparam logic [6:0] C_SHR_V  = 7'b0010000;
    localparam logic [6:0] C_INI_V  = 7'b0000001;
    localparam logic [6:0] C_OUT_V  = 7'b1100000;

    typedef struct {
        logic [15:0] prod;
        int          edge_n;
    } exp_t;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   edge_cnt = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    booth_datapath_if bus ();

    booth_datapath dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every product_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.product_valid === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_valid: got product %0h expected no pulse",
                         bus.product);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("product", 32'(bus.product), 32'(e.prod));
                check("latency_edge", edge_cnt, e.edge_n);
            end
        end
    end

    task automatic scan_cycle();
        case (bus.q)
            2'b01:   bus.c = C_ADD_V;
            2'b10:   bus.c = C_SUB_V;
            default: bus.c = '0;
        endcase
    endtask

    task automatic run_mult(input logic [7:0] xv, input logic [7:0] yv,
                            input logic [15:0] ex);
        exp_t e;
        bus.x = xv;
        bus.y = yv;
        bus.c = C_IDLE_V;
        @(negedge clk);
        e.prod   = ex;
        e.edge_n = edge_cnt + 25;
        sb.push_back(e);
        for (int i = 0; i < N_ITER; i++) begin
            scan_cycle();
            @(negedge clk);
            bus.c = C_SHR_V;
            @(negedge clk);
            bus.c = '0;
            check("counted7_test", 32'(bus.counted7), 32'(i == N_ITER - 1));
            @(negedge clk);
        end
        bus.c = C_OUT_V;
        @(negedge clk);
        bus.c = '0;
        repeat (2) @(negedge clk);
        check("hold_end", 32'(bus.product), 32'(ex));
        bus.x = 8'h5A;
        bus.y = 8'hA5;
        bus.c = C_IDLE_V;
        repeat (3) @(negedge clk);
        check("hold_idle", 32'(bus.product), 32'(ex));
    endtask

    initial begin
        bus.x = '0;
        bus.y = '0;
        bus.c = '0;
        #12;
        check("rst_product", 32'(bus.product), 0);
        check("rst_q", 32'(bus.q), 0);
        check("rst_counted7", 32'(bus.counted7), 0);
        check("rst_valid", 32'(bus.product_valid), 0);
        @(negedge clk);
        rst_b = 1'b1;
        bus.c = C_IDLE_V;
        @(negedge clk);

        run_mult(8'hFD, 8'h05, 16'hFFF1);

        // Abort a multiplication part-way with an asynchronous reset.
        bus.x = 8'h07;
        bus.y = 8'h09;
        bus.c = C_IDLE_V;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            scan_cycle();
            @(negedge clk);
            bus.c = C_SHR_V;
            @(negedge clk);
            bus.c = '0;
            @(negedge clk);
        end
        #2 rst_b = 1'b0;
        #1;
        check("mid_rst_product", 32'(bus.product), 0);
        check("mid_rst_q", 32'(bus.q), 0);
        check("mid_rst_counted7", 32'(bus.counted7), 0);
        check("mid_rst_valid", 32'(bus.product_valid), 0);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        bus.c = C_IDLE_V;
        @(negedge clk);

        run_mult(8'h03, 8'h05, 16'h000F);
        run_mult(8'h05, 8'hFD, 16'hFFF1);
        run_mult(8'h80, 8'h80, 16'h4000);
        run_mult(8'h7F, 8'h80, 16'hC080);
        run_mult(8'h00, 8'hFF, 16'h0000);
        run_mult(8'hFF, 8'h01, 16'hFFFF);

        // Counter: init, then eight direct shift pulses.
        bus.y = 8'h00;
        bus.c = C_INI_V;
        @(negedge clk);
        bus.c = '0;
        check("cnt_init_counted7", 32'(bus.counted7), 0);
        for (int i = 1; i <= N_ITER; i++) begin
            bus.c = C_SHR_V;
            @(negedge clk);
            bus.c = '0;
            check("cnt_counted7", 32'(bus.counted7), 32'(i == N_ITER));
        end
        check("cnt_wrap", 32'(dut.cnt), 0);
        @(negedge clk);
        check("cnt_hold_counted7", 32'(bus.counted7), 1);
        bus.c = C_INI_V;
        @(negedge clk);
        bus.c = '0;
        check("cnt_reinit_counted7", 32'(bus.counted7), 0);

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL missing_valid: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/booth_datapath.md
# booth_datapath

Datapath for the 8-bit signed radix-2 Booth multiplier, directly downstream of the Booth control unit. Consumes the seven-bit control word `c[6:0]` and returns the Booth scan pair `q` and the iteration-done flag `counted7` that the controller's FSM branches on. Holds the multiplicand, accumulator, multiplier and counter registers, and presents the 16-bit product.

## Interface
- `W`, default 8: operand width; product is `2*W`. Only 8 is required and verified.
- `clk` input 1: single clock, rising edge.
- `rst_b` input 1: asynchronous, active-low reset.
- `x` input W: multiplicand, two's complement.
- `y` input W: multiplier, two's complement.
- `c` input 7: control word from the control unit; bit meanings are given under Operation.
- `q` output 2: `{Q[0], Q[-1]}`, combinational from registers.
- `counted7` output 1: high once the 8th shift has completed; registered.
- `product` output 2W: registered product.
- `product_valid` output 1: one-cycle pulse, registered, aligned with the `product` update.

## Operation
- Registers:
  - `M`: W+1 bits, sign-extended multiplicand.
  - `A`: W+1 bits, accumulator.
  - `Q`: W bits, multiplier.
  - `Qm1`: 1 bit, `Q[-1]`.
  - `cnt`: 3 bits.
  - `done`: 1 bit.
  - `product`: 16 bits.
  - `product_valid`: 1 bit.
- `A` is W+1 bits so that `0 - (-128)` and similar cases do not overflow; only `A[7:0]` reaches the product.
- `c[0]` is init:
  - `A<=0`, `Q<=y`, `Qm1<=0`, `cnt<=0`, `done<=0`.
- `c[1]` is load multiplicand: `M<={x[7],x}`.
- `c[0]` and `c[1]` arrive together every idle cycle. Operands are therefore re-sampled every idle cycle, and the values present on the edge where the controller leaves idle are the ones used.
- `c[2]` is add/sub enable:
  - `A<=A+M` when `c[3]=0`.
  - `A<=A-M` when `c[3]=1`.
  - Arithmetic is modulo 2^(W+1).
- `c[3]` without `c[2]` has no effect.
- `c[4]` is arithmetic right shift:
  - `{A,Q,Qm1} <= {A[W], A, Q}` shifted right by one.
  - `cnt<=cnt+1`, wrapping from 7 to 0.
  - If `cnt==7` at the shift, `done<=1`. This is the 8th shift.
- `counted7 = done`. It is low after init and high from the cycle after the 8th shift until the next `c[0]`.
- `c[5]` is output high: `product[15:8]<=A[7:0]`.
- `c[6]` is output low: `product[7:0]<=Q`.
- `product_valid` is 1 on the cycle following any edge where `c[5]` or `c[6]` was sampled high; it is 0 otherwise.
- Simultaneous bits:
  - If `c[0]` and `c[2]`/`c[4]` are high together, `c[0]` wins.
  - If `c[2]` and `c[4]` are high together, it is an illegal controller output; apply add first, then shift, using the summed value. The bench does not rely on this case.
- `product` holds its value until the next `c[5]`/`c[6]`. It is not cleared by `c[0]`.

## Timing
- Reset, asynchronous and applied immediately:
  - All registers are 0.
  - `q=2'b00`, `counted7=0`, `product=0`, `product_valid=0`.
- Reset mid-multiplication abandons the operation and leaves no partial product on `product`.
- All register updates occur on the rising edge where the corresponding `c` bit is sampled.
- `q` is valid in the cycle after any register update. It is combinational from flops only, with no path from `c`, so there is no combinational loop with the controller.
- With the control unit, the sequence is idle → (SCAN, SHIFT, TEST)×8 → OUTPUT. `product`/`product_valid` update on the 26th rising edge after the edge where `start` is sampled, counting the idle→SCAN edge as edge 1.
- In the TEST cycle of iteration 8, `counted7=1`. In TEST cycles of iterations 1–7, `counted7=0`.

## Structure
- Shared package `booth_pkg`:
  - `W` = 8.
  - Control-bit index constants `C_INIT=0`, `C_LDM=1`, `C_ADD=2`, `C_SUB=3`, `C_SHR=4`, `C_OUTH=5`, `C_OUTL=6`. The control unit and this block both use them.
  - Iteration count constant `N_ITER` = 8.
- One sub-module, `booth_addsub`: combinational (W+1)-bit adder/subtractor taking `A`, `M` and `sub`, returning the sum.
- Top wrapper `booth_multiplier`, outside this block, instantiates control unit plus datapath.

## Test plan
- Reset: assert `rst_b=0` mid-run → `product=0`, `q=00`, `counted7=0`, `product_valid=0` immediately. Release, then `x=3`, `y=5` → `product=16'h000F`.
- Signed: `x=-3`, `y=5` → `16'hFFF1`. `x=5`, `y=-3` → `16'hFFF1`.
- Overflow corner: `x=-128`, `y=-128` → `16'h4000`. `x=127`, `y=-128` → `16'hC080`.
- Zero and identity: `x=0`, `y=-1` → `16'h0000`. `x=-1`, `y=1` → `16'hFFFF`.
- Counter: direct-drive `c` with `c[0]`, then 8 `c[4]` pulses → `counted7` low after pulses 1–7 and high one cycle after the 8th. `cnt` wraps to 0. A new `c[0]` clears `counted7`.
- Latency and hold: with the controller, `product_valid` pulses exactly once, on edge 26 after `start`. `product` holds through END and through the next idle period until a new OUTPUT.
